// File: rtl/poly_tonegen.sv
// Polyphonic square-wave tone generator: note command allocator, NUM_VOICES phase
// accumulators, serial saturating mixer and a first-order sigma-delta 1-bit output.
module poly_tonegen #(
  parameter int NUM_VOICES = 4,
  parameter int PCM_W      = 16,
  parameter int CLK_DIV    = 512
) (
  input  logic                    clk_25m,
  input  logic                    reset,
  input  logic                    note_valid,
  output logic                    note_ready,
  input  logic [6:0]              note_code,
  input  logic                    note_on,
  input  logic [1:0]              note_vol,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic                    sample_strobe,
  output logic signed [PCM_W-1:0] pcm_out,
  output logic                    pwm_out
);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int MIX_W = $clog2(NUM_VOICES + 1);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int ACC_W = PCM_W + 5;
  localparam logic signed [ACC_W-1:0] PCM_MAX = $signed({{(ACC_W-PCM_W+1){1'b0}}, {(PCM_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] PCM_MIN = $signed({{(ACC_W-PCM_W+1){1'b1}}, {(PCM_W-1){1'b0}}});

  // Base values are round(f * 2^41 / 25e6) for notes 120..131 (CLK_DIV = 512), rescaled here.
  function automatic logic [31:0] scale_inc(input logic [63:0] base);
    return 32'((base * 64'(CLK_DIV) + 64'd256) / 64'd512);
  endfunction

  localparam logic [31:0] TOP [12] = '{
    scale_inc(64'd736410499),  scale_inc(64'd780199746),  scale_inc(64'd826592837),
    scale_inc(64'd875744606),  scale_inc(64'd927819089),  scale_inc(64'd982990083),
    scale_inc(64'd1041441715), scale_inc(64'd1103369062), scale_inc(64'd1168978801),
    scale_inc(64'd1238489898), scale_inc(64'd1312134339), scale_inc(64'd1390157907)
  };

  function automatic logic [31:0] phase_inc(input logic [6:0] n);
    logic [3:0] semi;
    logic [3:0] oct;
    semi = 4'(n % 7'd12);
    oct  = 4'(n / 7'd12);
    return TOP[semi] >> (4'd10 - oct);
  endfunction

  function automatic logic signed [ACC_W-1:0] voice_level(input logic act, input logic neg,
                                                          input logic [1:0] vol);
    logic signed [ACC_W-1:0] amp;
    amp = ACC_W'(1) << (PCM_W - 5 + int'(vol));
    if (!act) return '0;
    return neg ? -amp : amp;
  endfunction

  function automatic logic signed [PCM_W-1:0] sat_pcm(input logic signed [ACC_W-1:0] x);
    if (x > PCM_MAX) return {1'b0, {(PCM_W-1){1'b1}}};
    if (x < PCM_MIN) return {1'b1, {(PCM_W-1){1'b0}}};
    return x[PCM_W-1:0];
  endfunction

  typedef enum logic [1:0] {IDLE, SCAN, WRITE} state_t;
  state_t state, state_nxt;

  logic [6:0]             cmd_code;
  logic                   cmd_on;
  logic [1:0]             cmd_vol;
  logic [IDX_W-1:0]       scan_idx, match_idx, free_idx, steal_ptr, wr_idx;
  logic                   found_match, found_free;
  logic                   wr_on, wr_off, do_steal;
  logic [NUM_VOICES-1:0]  voice_act;
  logic [6:0]             voice_note  [NUM_VOICES];
  logic [1:0]             voice_vol   [NUM_VOICES];
  logic [31:0]            voice_phase [NUM_VOICES];
  logic [DIV_W-1:0]       div_cnt;
  logic                   accept;

  always_ff @(posedge clk_25m) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (note_valid) state_nxt = SCAN;
      SCAN:    if (scan_idx == IDX_W'(NUM_VOICES - 1)) state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb note_ready = (state == IDLE);

  assign accept = note_valid & note_ready;

  // Scan records the first same-note active voice and the first free voice.
  always_ff @(posedge clk_25m) begin
    if (reset) begin
      cmd_code    <= '0;
      cmd_on      <= 1'b0;
      cmd_vol     <= '0;
      scan_idx    <= '0;
      match_idx   <= '0;
      free_idx    <= '0;
      found_match <= 1'b0;
      found_free  <= 1'b0;
    end else if (accept) begin
      cmd_code    <= note_code;
      cmd_on      <= note_on;
      cmd_vol     <= note_vol;
      scan_idx    <= '0;
      match_idx   <= '0;
      free_idx    <= '0;
      found_match <= 1'b0;
      found_free  <= 1'b0;
    end else if (state == SCAN) begin
      if (!found_match && voice_act[scan_idx] && voice_note[scan_idx] == cmd_code) begin
        found_match <= 1'b1;
        match_idx   <= scan_idx;
      end
      if (!found_free && !voice_act[scan_idx]) begin
        found_free <= 1'b1;
        free_idx   <= scan_idx;
      end
      scan_idx <= scan_idx + 1'b1;
    end
  end

  always_comb begin
    wr_on    = 1'b0;
    wr_off   = 1'b0;
    do_steal = 1'b0;
    wr_idx   = steal_ptr;
    if (state == WRITE) begin
      if (cmd_on) begin
        wr_on = 1'b1;
        if (found_match)     wr_idx = match_idx;
        else if (found_free) wr_idx = free_idx;
        else                 do_steal = 1'b1;
      end else if (found_match) begin
        wr_off = 1'b1;
        wr_idx = match_idx;
      end
    end
  end

  always_ff @(posedge clk_25m) begin
    if (reset)         steal_ptr <= '0;
    else if (do_steal) steal_ptr <= (steal_ptr == IDX_W'(NUM_VOICES - 1)) ? '0 : steal_ptr + 1'b1;
  end

  // A write on the tick cycle wins over the phase advance for that voice.
  always_ff @(posedge clk_25m) begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (reset) begin
        voice_act[i]   <= 1'b0;
        voice_note[i]  <= '0;
        voice_vol[i]   <= '0;
        voice_phase[i] <= '0;
      end else if ((wr_on || wr_off) && wr_idx == IDX_W'(i)) begin
        voice_act[i] <= wr_on;
        if (wr_on) begin
          voice_note[i]  <= cmd_code;
          voice_vol[i]   <= cmd_vol;
          voice_phase[i] <= '0;
        end
      end else if (sample_strobe && voice_act[i]) begin
        voice_phase[i] <= voice_phase[i] + phase_inc(voice_note[i]);
      end
    end
  end

  always_ff @(posedge clk_25m) begin
    if (reset) voice_active <= '0;
    else       voice_active <= voice_act;
  end

  always_ff @(posedge clk_25m) begin
    if (reset)                                div_cnt <= '0;
    else if (div_cnt == DIV_W'(CLK_DIV - 1)) div_cnt <= '0;
    else                                      div_cnt <= div_cnt + 1'b1;
  end

  assign sample_strobe = (div_cnt == DIV_W'(CLK_DIV - 1));

  logic                    vld_p0;
  logic [MIX_W-1:0]        mix_idx_p0;
  logic signed [ACC_W-1:0] mix_acc_p0;
  logic signed [ACC_W-1:0] mix_term;

  always_comb begin
    mix_term = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (mix_idx_p0 == MIX_W'(i))
        mix_term = voice_level(voice_act[i], voice_phase[i][31], voice_vol[i]);
    end
  end

  // Stage p0: serial accumulation, one voice per cycle after the tick.
  always_ff @(posedge clk_25m) begin
    if (reset) begin
      vld_p0     <= 1'b0;
      mix_idx_p0 <= '0;
      mix_acc_p0 <= '0;
      pcm_out    <= '0;
    end else if (sample_strobe) begin
      vld_p0     <= 1'b1;
      mix_idx_p0 <= '0;
      mix_acc_p0 <= '0;
    end else if (vld_p0) begin
      if (mix_idx_p0 == MIX_W'(NUM_VOICES)) begin
        pcm_out <= sat_pcm(mix_acc_p0);
        vld_p0  <= 1'b0;
      end else begin
        mix_acc_p0 <= mix_acc_p0 + mix_term;
        mix_idx_p0 <= mix_idx_p0 + 1'b1;
      end
    end
  end

  // Sigma-delta on the offset-binary sample; the carry out is the bitstream.
  logic [PCM_W:0] sd_acc;

  always_ff @(posedge clk_25m) begin
    if (reset) sd_acc <= '0;
    else       sd_acc <= {1'b0, sd_acc[PCM_W-1:0]} + {1'b0, ~pcm_out[PCM_W-1], pcm_out[PCM_W-2:0]};
  end

  assign pwm_out = sd_acc[PCM_W];

endmodule

// File: tb/tb_poly_tonegen.sv
// Directed bench for poly_tonegen at default parameters (4 voices, 16-bit PCM, /512).
`timescale 1ns/1ps
module tb_poly_tonegen;
  localparam int NV    = 4;
  localparam int PCM_W = 16;

  logic                    clk_25m = 1'b0;
  logic                    reset = 1'b1;
  logic                    note_valid = 1'b0;
  logic                    note_ready;
  logic [6:0]              note_code = '0;
  logic                    note_on = 1'b0;
  logic [1:0]              note_vol = '0;
  logic [NV-1:0]           voice_active;
  logic                    sample_strobe;
  logic signed [PCM_W-1:0] pcm_out;
  logic                    pwm_out;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] st_note [12] = '{7'd60, 7'd64, 7'd67, 7'd72, 7'd76, 7'd60,
                               7'd76, 7'd64, 7'd60, 7'd50, 7'd64, 7'd50};
  logic       st_on   [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                               1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [3:0] st_exp  [12] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111,
                               4'b1110, 4'b1110, 4'b1111, 4'b1111, 4'b1111, 4'b1101};
  logic [6:0] bb_note [4]  = '{7'd60, 7'd62, 7'd64, 7'd65};

  poly_tonegen #(.NUM_VOICES(NV), .PCM_W(PCM_W), .CLK_DIV(512)) dut (
    .clk_25m       (clk_25m),
    .reset         (reset),
    .note_valid    (note_valid),
    .note_ready    (note_ready),
    .note_code     (note_code),
    .note_on       (note_on),
    .note_vol      (note_vol),
    .voice_active  (voice_active),
    .sample_strobe (sample_strobe),
    .pcm_out       (pcm_out),
    .pwm_out       (pwm_out)
  );

  always #20 clk_25m = ~clk_25m;
  always @(posedge clk_25m) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(output int c);
    int n = 0;
    do begin
      @(negedge clk_25m);
      n++;
    end while (!sample_strobe && n < 600);
    check("strobe_seen", sample_strobe, 1);
    c = cyc;
  endtask

  task automatic next_sample(output logic signed [PCM_W-1:0] s);
    int c;
    wait_strobe(c);
    repeat (6) @(negedge clk_25m);
    s = pcm_out;
  endtask

  // Returns on the falling edge right after the accepting clock edge.
  task automatic send(input logic [6:0] code, input logic on, input logic [1:0] vol);
    int n = 0;
    @(negedge clk_25m);
    note_valid = 1'b1;
    note_code  = code;
    note_on    = on;
    note_vol   = vol;
    while (!note_ready && n < 50) begin
      @(negedge clk_25m);
      n++;
    end
    check("send_ready", note_ready, 1);
    @(negedge clk_25m);
    note_valid = 1'b0;
  endtask

  initial begin
    #3_600_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, ones, cnt, n;
    int acc_c [4];
    logic signed [PCM_W-1:0] s;

    repeat (3) @(negedge clk_25m);
    check("rst_pcm", pcm_out, 0);
    check("rst_active", voice_active, 0);
    check("rst_ready", note_ready, 1);
    check("rst_strobe", sample_strobe, 0);
    check("rst_pwm", pwm_out, 0);
    reset = 1'b0;

    wait_strobe(c0);
    wait_strobe(c1);
    check("strobe_period", c1 - c0, 512);
    @(negedge clk_25m);
    check("strobe_width", sample_strobe, 0);

    repeat (2000) @(negedge clk_25m);
    check("idle_pcm", pcm_out, 0);
    check("idle_active", voice_active, 0);

    ones = 0;
    repeat (4096) begin
      @(negedge clk_25m);
      ones += int'(pwm_out);
    end
    check("pwm_density", ones, 2048);

    // A4 starts just after a tick, so the first sample seen carries one increment.
    wait_strobe(c0);
    send(7'd69, 1'b1, 2'd2);
    repeat (5) @(negedge clk_25m);
    check("a4_active_early", voice_active, 0);
    @(negedge clk_25m);
    check("a4_active", voice_active, 4'b0001);
    cnt = 0;
    next_sample(s);
    while (s == 16'sd8192 && cnt < 70) begin
      cnt++;
      next_sample(s);
    end
    check("a4_pos_run", cnt, 55);
    check("a4_neg", s, -8192);

    send(7'd69, 1'b0, 2'd0);
    repeat (6) @(negedge clk_25m);
    check("off69_active", voice_active, 0);
    next_sample(s);
    check("off69_pcm", s, 0);

    send(7'd50, 1'b0, 2'd0);
    repeat (4) @(negedge clk_25m);
    check("off50_busy", note_ready, 0);
    @(negedge clk_25m);
    check("off50_ready", note_ready, 1);
    check("off50_active", voice_active, 0);

    for (int i = 0; i < 12; i++) begin
      send(st_note[i], st_on[i], 2'd0);
      repeat (6) @(negedge clk_25m);
      check($sformatf("alloc%0d", i), voice_active, st_exp[i]);
    end

    next_sample(s);
    check("pre_rst_pcm_nonzero", s != 0, 1);
    send(7'd90, 1'b1, 2'd3);
    reset = 1'b1;
    @(negedge clk_25m);
    reset = 1'b0;
    check("scanrst_active", voice_active, 0);
    check("scanrst_ready", note_ready, 1);
    check("scanrst_pcm", pcm_out, 0);
    repeat (8) @(negedge clk_25m);
    check("scanrst_aborted", voice_active, 0);

    @(negedge clk_25m);
    note_valid = 1'b1;
    note_on    = 1'b1;
    note_vol   = 2'd1;
    note_code  = bb_note[0];
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!note_ready && n < 20) begin
        @(negedge clk_25m);
        n++;
      end
      check("bb_ready", note_ready, 1);
      acc_c[i] = cyc;
      @(negedge clk_25m);
      if (i < 3) note_code = bb_note[i+1];
      else       note_valid = 1'b0;
    end
    for (int i = 1; i < 4; i++) check($sformatf("bb_gap%0d", i), acc_c[i] - acc_c[i-1], 6);
    repeat (6) @(negedge clk_25m);
    check("bb_active", voice_active, 4'b1111);

    reset = 1'b1;
    @(negedge clk_25m);
    reset = 1'b0;
    check("rst2_active", voice_active, 0);

    // Four A octaves written between two ticks: in phase at tick 1, all negative at tick 53.
    wait_strobe(c0);
    send(7'd81,  1'b1, 2'd3);
    send(7'd93,  1'b1, 2'd3);
    send(7'd105, 1'b1, 2'd3);
    send(7'd117, 1'b1, 2'd3);
    next_sample(s);
    check("sat_pos", s, 32767);
    check("sat_active", voice_active, 4'b1111);
    repeat (52) next_sample(s);
    check("sat_neg", s, -32768);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/poly_tonegen.md
Name: poly_tonegen

Overview:
- Polyphonic successor to the single-voice MIDI tone generator.
- Accepts note-on/note-off commands over a valid/ready handshake and allocates them to NUM_VOICES square-wave voices.
- Mixes the voices with saturation into a signed PCM sample stream, and produces a first-order sigma-delta 1-bit output for the jack pins.
- pcm_out feeds the FM transmitter's pcm input; pwm_out replaces the old PWM tone.

Parameters:
NUM_VOICES, 4, number of simultaneous voices (2..16)
PCM_W, 16, signed PCM output width (>=8)
CLK_DIV, 512, clocks per sample; Fs = 25 MHz / CLK_DIV (48828.125 Hz default)

Ports:
clk_25m  in  1  system clock, 25 MHz
reset  in  1  synchronous, active-high reset
note_valid  in  1  command valid
note_ready  out  1  block can accept a command
note_code  in  7  MIDI note 0..127
note_on  in  1  1 = note-on, 0 = note-off
note_vol  in  2  volume 0..3 (note-on only)
voice_active  out  NUM_VOICES  per-voice active flag
sample_strobe  out  1  one-cycle pulse at each sample tick
pcm_out  out  PCM_W  signed mixed sample
pwm_out  out  1  sigma-delta bitstream

Behaviour:
- Reset: all outputs 0 except note_ready = 1. All voices inactive, phases 0, divider 0, steal_ptr 0, sigma-delta accumulator 0.
- Command FSM: IDLE -> SCAN -> WRITE -> IDLE.
  - IDLE: note_ready = 1; a command is captured when note_valid & note_ready.
  - SCAN: examines one voice per cycle, NUM_VOICES cycles, with note_ready = 0.
  - WRITE: 1 cycle, updates voice registers. note_ready returns to 1 the following cycle.
- Latency: voice_active changes NUM_VOICES+2 cycles after the accept edge.
- Note-on allocation priority:
  - (1) an active voice with the same note: retrigger, new volume, phase reset to 0;
  - (2) the lowest-index inactive voice;
  - (3) otherwise steal voice steal_ptr, then steal_ptr = (steal_ptr+1) mod NUM_VOICES.
  - steal_ptr changes only on a steal.
- Note-off: deactivates the lowest-index active voice with a matching note. No match: the command is consumed with no effect.
- Voice state: active, note[6:0], vol[1:0], phase[31:0]. Note-on clears the phase.
- Phase increment:
  - inc(n) = TOP[n mod 12] >> (10 - n/12).
  - TOP is a 12-entry 32-bit constant ROM of round(f * 2^32 / Fs) for notes 120..131, f = 440 * 2^((m-69)/12), generated for the configured CLK_DIV.
  - Default A4 (n=69): inc ≈ 38702809.
- Sample tick:
  - Divider counts 0..CLK_DIV-1; at CLK_DIV-1, sample_strobe = 1 for one cycle.
  - On that cycle every active voice does phase += inc, with natural 32-bit wrap.
  - Inactive voices keep their phase.
- Voice value: +amp if phase[31] = 0, -amp if 1; 0 if inactive. amp = 1 << (PCM_W-5+vol), i.e. 2048/4096/8192/16384 for PCM_W = 16.
- Mixer:
  - Starting the cycle after the strobe, accumulates one voice per cycle into a PCM_W+5 bit signed sum over NUM_VOICES cycles.
  - Next cycle, saturates to [-2^(PCM_W-1), 2^(PCM_W-1)-1] and registers into pcm_out.
  - pcm_out updates NUM_VOICES+1 cycles after the strobe and holds until the next update. Requires CLK_DIV > NUM_VOICES+2.
- Command vs. sample tick: a WRITE on the strobe cycle takes effect for phase at the next tick. The mixer uses voice state as sampled during accumulation.
- Sigma-delta, every cycle:
  - u = pcm_out with MSB inverted (offset binary).
  - acc (PCM_W+1 bits) = acc[PCM_W-1:0] + u.
  - pwm_out = registered acc[PCM_W] (carry).
  - Duty = u / 2^PCM_W.
- Reset mid-command (e.g. during SCAN): the command is aborted, all voices are cleared and note_ready = 1 the cycle after reset deasserts.

Test Plan:
- Reset, then idle 2000 cycles -> pcm_out = 0, voice_active = 0, sample_strobe period exactly 512 cycles, pwm_out density 50% ±1 over 65536 cycles.
- Note-on 69 vol 2 -> voice_active = 4'b0001 exactly 6 cycles after accept. pcm_out alternates +8192/-8192 with a half-period of 55–56 samples (440 Hz ±0.5%).
- Note-on 60, 64, 67, 72, then 76 (all vol 0) -> first four occupy voices 0..3. Note 76 steals voice 0, then steal_ptr = 1. Note-on 64 again retriggers voice 1 and leaves steal_ptr at 1.
- Four note-on 69 vol 3 impossible (retrigger) -> instead use notes 69, 81, 93, 105 vol 3 at the first sample after simultaneous start -> sum 65536, pcm_out saturates to 32767. All four negative -> -32768.
- Note-off 50 with no voice playing it -> no change, note_ready high again after 6 cycles. Note-off 69 while active -> voice cleared, its contribution becomes 0 at the next mixer update.
- Hold note_valid high with back-to-back commands -> each accepted only when note_ready = 1, one command per 6 cycles, none lost. Assert reset during SCAN -> all voices off, pcm_out = 0 next cycle.
